ahb_wrr_burst_arbiter: RTL

- Shares one AHB slave port between MASTER_NUM masters using weighted round-robin.
- Grant is held for a whole burst, with beats counted from each master's own hburst. A grant is never revoked mid-burst.
- Sits in the per-slave interconnect path, replacing the single-path/fixed arbiters where several masters target one slave.
- Drives hgrant/hsel to the mux and decoder logic; hmaster steers the address/data mux.

---
 rtl/ahb_wrr_burst_arbiter_pkg.sv | 37 +++
 rtl/ahb_wrr_burst_arbiter_if.sv | 33 +++
 rtl/ahb_wrr_burst_arbiter_rr_pick.sv | 41 ++++
 rtl/ahb_wrr_burst_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_wrr_burst_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ahb_wrr_burst_arbiter_pkg
// Shared types for the weighted round-robin AHB burst arbiter:
//   hburst_t    - AHB HBURST encoding
//   arb_state_t - arbiter FSM states
//   burst_len() - beats per burst type; undefined-length INCR is capped at 16
// ---------------------------------------------------------------------------
package ahb_wrr_burst_arbiter_pkg;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } arb_state_t;

  // INCR has no natural length; the cap bounds how long one owner can hold
  // the slave so other masters cannot be locked out.
  function automatic logic [4:0] burst_len(input hburst_t b);
    case (b)
      SINGLE:         return 5'd1;
      WRAP4,  INCR4:  return 5'd4;
      WRAP8,  INCR8:  return 5'd8;
      default:        return 5'd16;  // WRAP16, INCR16, INCR cap
    endcase
  endfunction

endpackage

// File: rtl/ahb_wrr_burst_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_wrr_burst_arbiter_if
// Request/grant bundle between the masters (plus the slave's stall) and the
// arbiter.
//   hreq[M]      per-master request level
//   hburst[M]    per-master HBURST (hburst_t encoding)
//   hwait        slave stall, beat completes when low
//   hgrant[M]    one-hot grant
//   hsel         any grant active
//   hmaster      index of the owner, steers the address/data mux
//   hlast        final beat of the owner's burst
// Modports: master = requesting side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ahb_wrr_burst_arbiter_if #(
  parameter int MASTER_NUM = 4
);
  localparam int IW = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0]      hreq;
  logic [MASTER_NUM-1:0][2:0] hburst;
  logic                       hwait;
  logic [MASTER_NUM-1:0]      hgrant;
  logic                       hsel;
  logic [IW-1:0]              hmaster;
  logic                       hlast;

  modport master (output hreq, hburst, hwait,
                  input  hgrant, hsel, hmaster, hlast);

  modport slave  (input  hreq, hburst, hwait,
                  output hgrant, hsel, hmaster, hlast);

endinterface

// File: rtl/ahb_wrr_burst_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_wrr_burst_arbiter_rr_pick
// Combinational rotate-priority encoder. Searches req_i starting at
// ptr_i+1 and wrapping, so the master at ptr_i has the lowest priority.
//   req_i[N]    request vector
//   ptr_i       last-served index
//   grant_o[N]  one-hot winner
//   idx_o       winner index
//   valid_o     any request present
// ---------------------------------------------------------------------------
module ahb_wrr_burst_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW-1:0] cand;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (valid_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/ahb_wrr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_wrr_burst_arbiter
// Weighted round-robin arbiter sharing one AHB slave port between
// MASTER_NUM masters. A grant covers a whole burst; a master may take up
// to weight_cfg consecutive bursts before the round-robin moves on.
//   hclk        clock
//   hreset      asynchronous active-high reset
//   weight_cfg  per-master weight (0 behaves as 1), sampled on reload
//   bus         ahb_wrr_burst_arbiter_if.slave (hreq/hburst/hwait in,
//               hgrant/hsel/hmaster/hlast out)
// Build option: define AHB_ARB_STARVE_TIMEOUT_EN to add per-master wait
// counters; a master waiting TIMEOUT_CYC cycles wins the next arbitration.
// ---------------------------------------------------------------------------
module ahb_wrr_burst_arbiter
  import ahb_wrr_burst_arbiter_pkg::*;
#(
  parameter int MASTER_NUM  = 4,
  parameter int WEIGHT_BIT  = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                  hclk,
  input  logic                                  hreset,
  input  logic [MASTER_NUM-1:0][WEIGHT_BIT-1:0] weight_cfg,
  ahb_wrr_burst_arbiter_if.slave                bus
);

  localparam int IW = $clog2(MASTER_NUM);

  arb_state_t                            state_q;
  logic [MASTER_NUM-1:0]                 grant_q;
  logic [IW-1:0]                         owner_q;
  logic [IW-1:0]                         rr_ptr_q;
  hburst_t                               burst_q;
  logic [3:0]                            count_q;
  logic [MASTER_NUM-1:0][WEIGHT_BIT-1:0] credit_q;
  // A clear bit means "credit is a full weight": the first burst after
  // reset reads weight_cfg directly instead of loading it during reset.
  logic [MASTER_NUM-1:0]                 credit_vld_q;

  logic                  own_req, last_beat, burst_end, keep_owner, arb_point;
  logic [WEIGHT_BIT-1:0] own_credit, credit_left;
  logic [IW-1:0]         pick_ptr, pick_idx, win_idx, starve_idx;
  logic [MASTER_NUM-1:0] pick_oh, win_oh;
  logic                  pick_vld, win_vld, starve_vld;

  function automatic logic [WEIGHT_BIT-1:0] eff_weight(input logic [WEIGHT_BIT-1:0] w);
    return (w == '0) ? WEIGHT_BIT'(1) : w;
  endfunction

  assign own_req     = bus.hreq[owner_q];
  assign own_credit  = credit_vld_q[owner_q] ? credit_q[owner_q]
                                             : eff_weight(weight_cfg[owner_q]);
  assign credit_left = own_credit - WEIGHT_BIT'(1);

  // INCR ends when the owner lets go of hreq or at the 16-beat cap; fixed
  // bursts ignore hreq and run to their length.
  always_comb begin
    last_beat = 1'b0;
    if (state_q == S_OWN) begin
      if (burst_q == INCR) last_beat = !own_req || (count_q == 4'd15);
      else                 last_beat = ({1'b0, count_q} == burst_len(burst_q) - 5'd1);
    end
  end

  assign burst_end  = (state_q == S_OWN) && last_beat && !bus.hwait;
  assign keep_owner = burst_end && (credit_left != '0) && own_req;
  assign arb_point  = (state_q == S_IDLE) || burst_end;
  // At a burst end the owner becomes the lowest-priority candidate.
  assign pick_ptr   = (state_q == S_IDLE) ? rr_ptr_q : owner_q;

  ahb_wrr_burst_arbiter_rr_pick #(.N(MASTER_NUM), .PW(IW)) u_rr_pick (
    .req_i   (bus.hreq),
    .ptr_i   (pick_ptr),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

`ifdef AHB_ARB_STARVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [MASTER_NUM-1:0][TW-1:0] wait_q;

  // Descending scan so the lowest starved index is the one left standing.
  always_comb begin
    starve_vld = 1'b0;
    starve_idx = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (bus.hreq[i] && (wait_q[i] == TW'(TIMEOUT_CYC))) begin
        starve_vld = 1'b1;
        starve_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wait_q <= '0;
    end else begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (grant_q[i] || (arb_point && win_vld && win_oh[i]))
          wait_q[i] <= '0;
        else if (bus.hreq[i] && (wait_q[i] != TW'(TIMEOUT_CYC)))
          wait_q[i] <= wait_q[i] + TW'(1);
      end
    end
  end
`else
  assign starve_vld = 1'b0;
  assign starve_idx = '0;
  // TIMEOUT_CYC only drives logic when the starvation timeout is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // Priority at an arbitration point: starved master, then credit
  // continuation of the owner, then plain round-robin.
  always_comb begin
    win_vld = 1'b0;
    win_idx = pick_idx;
    win_oh  = '0;
    if (arb_point) begin
      if (starve_vld) begin
        win_vld             = 1'b1;
        win_idx             = starve_idx;
        win_oh[starve_idx]  = 1'b1;
      end else if (keep_owner) begin
        win_vld = 1'b1;
        win_idx = owner_q;
        win_oh  = grant_q;
      end else begin
        win_vld = pick_vld;
        win_idx = pick_idx;
        win_oh  = pick_oh;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= IW'(MASTER_NUM - 1);
      burst_q      <= SINGLE;
      count_q      <= '0;
      // NOTE: the credit array is a handful of flops, not a RAM, so it is
      // reset like any other register.
      credit_q     <= '0;
      credit_vld_q <= '0;
    end else begin
      if (arb_point) begin
        count_q <= '0;
        if (win_vld) begin
          state_q <= S_OWN;
          grant_q <= win_oh;
          owner_q <= win_idx;
          burst_q <= hburst_t'(bus.hburst[win_idx]);
        end else begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      end else if ((state_q == S_OWN) && !bus.hwait) begin
        count_q <= count_q + 4'd1;
      end

      if (burst_end) begin
        credit_vld_q[owner_q] <= 1'b1;
        if (keep_owner) begin
          credit_q[owner_q] <= credit_left;
        end else begin
          credit_q[owner_q] <= eff_weight(weight_cfg[owner_q]);
          rr_ptr_q          <= owner_q;
        end
      end
    end
  end

  assign bus.hgrant  = grant_q;
  assign bus.hsel    = |grant_q;
  assign bus.hmaster = owner_q;
  assign bus.hlast   = last_beat;

endmodule
